// File: rtl/stats_pkg.sv
// Shared command codes, counter indices and FSM state encoding for the
// stats sequencer slice.
package stats_pkg;

    localparam int unsigned CMD_W   = 4;
    localparam int unsigned NUM_CNT = 7;
    localparam int unsigned HOLD_W  = 4;

    localparam logic [CMD_W-1:0] CMD_DREAD  = 4'd0;
    localparam logic [CMD_W-1:0] CMD_DWRITE = 4'd1;
    localparam logic [CMD_W-1:0] CMD_IFETCH = 4'd2;
    localparam logic [CMD_W-1:0] CMD_CLEAR  = 4'd8;
    localparam logic [CMD_W-1:0] CMD_PRINT  = 4'd9;

    // Slot of each statistic in the live-counter and snapshot arrays
    localparam int unsigned IDX_INS_READS   = 0;
    localparam int unsigned IDX_INS_HIT     = 1;
    localparam int unsigned IDX_INS_MISS    = 2;
    localparam int unsigned IDX_DATA_READS  = 3;
    localparam int unsigned IDX_DATA_WRITES = 4;
    localparam int unsigned IDX_DATA_HIT    = 5;
    localparam int unsigned IDX_DATA_MISS   = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_PRINT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/stats_sequencer_if.sv
// Command handshake from the trace driver plus the print trigger and
// snapshot bus towards the statistics display block.
interface stats_sequencer_if
    import stats_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic             cmd_valid;
    logic [CMD_W-1:0] cmd;
    logic             hit;
    logic             cmd_ready;
    logic             print;
    logic [CNT_W-1:0] ins_reads;
    logic [CNT_W-1:0] ins_hit;
    logic [CNT_W-1:0] ins_miss;
    logic [CNT_W-1:0] data_reads;
    logic [CNT_W-1:0] data_writes;
    logic [CNT_W-1:0] data_hit;
    logic [CNT_W-1:0] data_miss;

    modport master (
        output cmd_valid, cmd, hit,
        input  cmd_ready, print,
        input  ins_reads, ins_hit, ins_miss,
        input  data_reads, data_writes, data_hit, data_miss
    );

    modport slave (
        input  cmd_valid, cmd, hit,
        output cmd_ready, print,
        output ins_reads, ins_hit, ins_miss,
        output data_reads, data_writes, data_hit, data_miss
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority
// over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);
    logic [CNT_W-1:0] r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc && (r_value != '1)) begin
            r_value <= r_value + CNT_W'(1);
        end
    end

    assign value = r_value;
endmodule

// File: rtl/stats_sequencer.sv
// Cache-trace statistics: seven saturating live counters, a snapshot bank,
// and an IDLE/SNAP/PRINT/GAP sequencer that pulses print for the display.
module stats_sequencer
    import stats_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PRINT_HOLD = 2
) (
    input  logic               clk,
    input  logic               rst,
    stats_sequencer_if.slave   bus
);
    state_t              r_state;
    state_t              w_next_state;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_next;
    logic                r_cmd_ready;
    logic                r_print;
    logic                w_accept;
    logic                w_clr;
    logic                w_snap_load;
    logic [NUM_CNT-1:0]  w_inc;
    logic [CNT_W-1:0]    w_live [NUM_CNT];
    logic [CNT_W-1:0]    r_snap [NUM_CNT];

    // cmd_ready is only ever high in IDLE, so an accept implies IDLE
    assign w_accept    = bus.cmd_valid && r_cmd_ready;
    assign w_snap_load = (r_state == ST_SNAP);

    always_comb begin
        w_inc = '0;
        w_clr = 1'b0;
        if (w_accept) begin
            case (bus.cmd)
                CMD_DREAD: begin
                    w_inc[IDX_DATA_READS] = 1'b1;
                    w_inc[IDX_DATA_HIT]   = bus.hit;
                    w_inc[IDX_DATA_MISS]  = !bus.hit;
                end
                CMD_DWRITE: begin
                    w_inc[IDX_DATA_WRITES] = 1'b1;
                    w_inc[IDX_DATA_HIT]    = bus.hit;
                    w_inc[IDX_DATA_MISS]   = !bus.hit;
                end
                CMD_IFETCH: begin
                    w_inc[IDX_INS_READS] = 1'b1;
                    w_inc[IDX_INS_HIT]   = bus.hit;
                    w_inc[IDX_INS_MISS]  = !bus.hit;
                end
                CMD_CLEAR: w_clr = 1'b1;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (w_clr),
            .inc   (w_inc[g]),
            .value (w_live[g])
        );
    end

    always_comb begin
        w_next_state = r_state;
        w_hold_next  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (bus.cmd == CMD_PRINT)) begin
                    w_next_state = ST_SNAP;
                end
            end
            ST_SNAP: begin
                w_next_state = ST_PRINT;
            end
            ST_PRINT: begin
                if (r_hold == HOLD_W'(PRINT_HOLD - 1)) begin
                    w_next_state = ST_GAP;
                end else begin
                    w_hold_next = r_hold + HOLD_W'(1);
                end
            end
            ST_GAP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_cmd_ready <= 1'b1;
            r_print     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_hold      <= w_hold_next;
            r_cmd_ready <= (w_next_state == ST_IDLE);
            r_print     <= (w_next_state == ST_PRINT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_snap_load) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                r_snap[i] <= w_live[i];
            end
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.print       = r_print;
    assign bus.ins_reads   = r_snap[IDX_INS_READS];
    assign bus.ins_hit     = r_snap[IDX_INS_HIT];
    assign bus.ins_miss    = r_snap[IDX_INS_MISS];
    assign bus.data_reads  = r_snap[IDX_DATA_READS];
    assign bus.data_writes = r_snap[IDX_DATA_WRITES];
    assign bus.data_hit    = r_snap[IDX_DATA_HIT];
    assign bus.data_miss   = r_snap[IDX_DATA_MISS];
endmodule
